// File: rtl/register_snapshot_reader_if.sv
// Output link of the register snapshot reader.
// Carries one word per valid/ready handshake toward the visualizer/debug port.
//   out_valid  word, index and last are valid (driven by master)
//   out_data   register word or checksum word (driven by master)
//   out_index  0..NREGS-1 = register number, NREGS = checksum (driven by master)
//   out_last   high while the checksum word is presented (driven by master)
//   out_ready  consumer accepts the current word (driven by slave)
interface register_snapshot_reader_if #(
   parameter int N  = 8,
   parameter int IW = 4
);
   logic          out_valid;
   logic [N-1:0]  out_data;
   logic [IW-1:0] out_index;
   logic          out_last;
   logic          out_ready;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/register_snapshot_reader.sv
// Captures all general-purpose registers on one clock edge when start is seen
// in IDLE. It then streams the captured words in order, followed by their XOR
// checksum, over a valid/ready link. It never writes the register bank.
//   clk      system clock, rising edge
//   Reset    asynchronous, active-high reset
//   REGS_IN  register bank outputs, word i = REGS_IN[i*N +: N]
//   start    snapshot request, ignored while busy
//   link     output stream (master side of register_snapshot_reader_if)
//   busy     snapshot stream in progress
//   done     one-cycle pulse after the checksum word is accepted
module register_snapshot_reader #(
   parameter int N     = 8,
   parameter int NREGS = 4,
   parameter int IW    = 4
) (
   input  logic                        clk,
   input  logic                        Reset,
   input  logic [NREGS*N-1:0]          REGS_IN,
   input  logic                        start,
   register_snapshot_reader_if.master  link,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state, state_n;
   logic [IW-1:0] idx, idx_n, idx_inc;
   logic [N-1:0]  snap [NREGS];
   logic [N-1:0]  csum, csum_in;
   logic [N-1:0]  next_word;
   logic [N-1:0]  data_n;
   logic          valid_n, last_n, done_n;
   logic          capture;
   logic          hs;

   // XOR of the live register words, latched together with the snapshot
   always_comb begin
      csum_in = '0;
      for (int unsigned i = 0; i < NREGS; i++)
         csum_in = csum_in ^ REGS_IN[i*N +: N];
   end

   // Word presented after the next advance; no register matches when the
   // advanced index equals NREGS, so the checksum falls through.
   always_comb begin
      idx_inc   = idx + 1'b1;
      next_word = csum;
      for (int unsigned i = 0; i < NREGS; i++)
         if (idx_inc == IW'(i))
            next_word = snap[i];
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next-state and next-output logic; outputs themselves are registered below
   always_comb begin
      state_n = state;
      idx_n   = idx;
      data_n  = link.out_data;
      valid_n = link.out_valid;
      last_n  = link.out_last;
      done_n  = 1'b0;
      capture = 1'b0;
      hs      = link.out_valid && link.out_ready;
      case (state)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_n = SEND;
               idx_n   = '0;
               data_n  = REGS_IN[N-1:0];
               valid_n = 1'b1;
               last_n  = 1'b0;
            end
         end
         SEND: begin
            if (hs) begin
               if (idx == IW'(NREGS)) begin
                  state_n = IDLE;
                  idx_n   = '0;
                  data_n  = '0;
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  idx_n  = idx_inc;
                  data_n = next_word;
                  last_n = (idx_inc == IW'(NREGS));
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         idx            <= '0;
         csum           <= '0;
         for (int unsigned i = 0; i < NREGS; i++)
            snap[i] <= '0;
         link.out_valid <= 1'b0;
         link.out_data  <= '0;
         link.out_index <= '0;
         link.out_last  <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         if (capture) begin
            csum <= csum_in;
            for (int unsigned i = 0; i < NREGS; i++)
               snap[i] <= REGS_IN[i*N +: N];
         end
         idx            <= idx_n;
         link.out_valid <= valid_n;
         link.out_data  <= data_n;
         link.out_index <= idx_n;
         link.out_last  <= last_n;
         busy           <= (state_n == SEND);
         done           <= done_n;
      end
   end

endmodule

// File: tb/tb_register_snapshot_reader.sv
module tb_register_snapshot_reader;
   localparam int N     = 8;
   localparam int NREGS = 4;
   localparam int IW    = 4;

   logic               clk = 1'b0;
   logic               Reset;
   logic               start;
   logic [NREGS*N-1:0] regs;
   logic               busy;
   logic               done;
   int                 checks = 0;
   int                 errors = 0;

   logic [7:0] ew [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};

   register_snapshot_reader_if #(.N(N), .IW(IW)) link ();

   register_snapshot_reader #(.N(N), .NREGS(NREGS), .IW(IW)) dut (
      .clk     (clk),
      .Reset   (Reset),
      .REGS_IN (regs),
      .start   (start),
      .link    (link),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      start = 1'b0;
      link.out_ready = 1'b0;
      regs = '0;
      #2;
      checks++;
      if ({link.out_valid, busy, done, link.out_last, link.out_index, link.out_data} !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b busy=%b done=%b last=%b index=%0d data=%h, required all zero",
                  link.out_valid, busy, done, link.out_last, link.out_index, link.out_data);
      end
      step;
      step;
      Reset = 1'b0;
      step;
      checks++;
      if (link.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: valid=%b busy=%b done=%b, required 0 0 0",
                  link.out_valid, busy, done);
      end
   endtask

   task automatic test_basic;
      regs = {8'h78, 8'h56, 8'h34, 8'h12};
      link.out_ready = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (link.out_valid !== 1'b1 || busy !== 1'b1 || link.out_index !== IW'(k) ||
             link.out_data !== ew[k] || link.out_last !== (k == 4) || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_word%0d: valid=%b busy=%b index=%0d data=%h last=%b done=%b, required 1 1 %0d %h %b 0",
                     k, link.out_valid, busy, link.out_index, link.out_data, link.out_last, done,
                     k, ew[k], (k == 4));
         end
         step;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || link.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done=%b busy=%b valid=%b, required 1 0 0", done, busy, link.out_valid);
      end
      step;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_clear: done=%b, required 0", done);
      end
   endtask

   task automatic test_atomicity;
      regs = {8'h78, 8'h56, 8'h34, 8'h12};
      link.out_ready = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      regs = '1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (link.out_valid !== 1'b1 || link.out_index !== IW'(k) || link.out_data !== ew[k]) begin
            errors++;
            $display("FAIL atomic_word%0d: valid=%b index=%0d data=%h, required 1 %0d %h",
                     k, link.out_valid, link.out_index, link.out_data, k, ew[k]);
         end
         step;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL atomic_done: done=%b, required 1", done);
      end
      step;
   endtask

   task automatic test_backpressure;
      int rp [8] = '{1, 0, 0, 1, 0, 1, 1, 1};
      int ei;
      regs = {8'h78, 8'h56, 8'h34, 8'h12};
      link.out_ready = 1'b0;
      start = 1'b1;
      step;
      start = 1'b0;
      ei = 0;
      for (int c = 0; c < 8; c++) begin
         link.out_ready = rp[c][0];
         checks++;
         if (link.out_valid !== 1'b1 || link.out_index !== IW'(ei) || link.out_data !== ew[ei] ||
             link.out_last !== (ei == 4)) begin
            errors++;
            $display("FAIL bp_cycle%0d: valid=%b index=%0d data=%h last=%b, required 1 %0d %h %b",
                     c, link.out_valid, link.out_index, link.out_data, link.out_last, ei, ew[ei], (ei == 4));
         end
         step;
         if (rp[c] != 0) ei++;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || link.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_done: done=%b busy=%b valid=%b, required 1 0 0", done, busy, link.out_valid);
      end
      link.out_ready = 1'b1;
      step;
   endtask

   task automatic test_start_busy;
      regs = {8'h78, 8'h56, 8'h34, 8'h12};
      link.out_ready = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (link.out_index !== IW'(k) || link.out_data !== ew[k] || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_word%0d: index=%0d data=%h done=%b, required %0d %h 0",
                     k, link.out_index, link.out_data, done, k, ew[k]);
         end
         start = (k == 2 || k == 4);
         step;
         start = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || link.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL busy_done: done=%b valid=%b, required 1 0", done, link.out_valid);
      end
      step;
      checks++;
      if (done !== 1'b0 || link.out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_no_requeue: done=%b valid=%b busy=%b, required 0 0 0",
                  done, link.out_valid, busy);
      end
   endtask

   task automatic test_reset_mid;
      regs = {8'h78, 8'h56, 8'h34, 8'h12};
      link.out_ready = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      for (int k = 0; k < 3; k++) step;
      checks++;
      if (link.out_index !== IW'(3) || link.out_data !== 8'h78) begin
         errors++;
         $display("FAIL rst_pre_index: index=%0d data=%h, required 3 78", link.out_index, link.out_data);
      end
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if ({link.out_valid, busy, done, link.out_last, link.out_index, link.out_data} !== '0) begin
         errors++;
         $display("FAIL rst_async: valid=%b busy=%b done=%b last=%b index=%0d data=%h, required all zero",
                  link.out_valid, busy, done, link.out_last, link.out_index, link.out_data);
      end
      step;
      step;
      Reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step;
         checks++;
         if (link.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_stay_idle%0d: valid=%b busy=%b done=%b, required 0 0 0",
                     c, link.out_valid, busy, done);
         end
      end
      start = 1'b1;
      step;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (link.out_valid !== 1'b1 || link.out_index !== IW'(k) || link.out_data !== ew[k]) begin
            errors++;
            $display("FAIL rst_restream_word%0d: valid=%b index=%0d data=%h, required 1 %0d %h",
                     k, link.out_valid, link.out_index, link.out_data, k, ew[k]);
         end
         step;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL rst_restream_done: done=%b, required 1", done);
      end
      step;
   endtask

   task automatic test_checksum;
      logic [NREGS*N-1:0] vin [2];
      logic [7:0]         vck [2];
      vin[0] = {4{8'hA5}};
      vck[0] = 8'h00;
      vin[1] = {8'h00, 8'h00, 8'h00, 8'h01};
      vck[1] = 8'h01;
      link.out_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         regs = vin[t];
         start = 1'b1;
         step;
         start = 1'b0;
         for (int k = 0; k < 4; k++) step;
         checks++;
         if (link.out_index !== IW'(4) || link.out_last !== 1'b1 || link.out_data !== vck[t]) begin
            errors++;
            $display("FAIL checksum%0d: index=%0d last=%b data=%h, required 4 1 %h",
                     t, link.out_index, link.out_last, link.out_data, vck[t]);
         end
         step;
         step;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_atomicity;
      test_backpressure;
      test_start_busy;
      test_reset_mid;
      test_checksum;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
